// File: rtl/rfa_regbank.sv
// rfa_regbank: accumulator write-back register bank. Holds 14 registers that
// can be loaded from the accumulator bus, incremented or cleared.
// Optional build macro RFA_SAT_EN: increments saturate at all-ones instead of
// wrapping to zero; wrap then flags the attempted increment at saturation.
module rfa_regbank #(
  parameter int unsigned WIDE_W   = 16,
  parameter int unsigned NARROW_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          RFA_sel,
  input  logic                RFA_en,
  input  logic [WIDE_W-1:0]   datain,
  input  logic [3:0]          INC_sel,
  input  logic                INC_en,
  input  logic [3:0]          CLR_sel,
  input  logic                CLR_en,
  output logic [NARROW_W-1:0] rfa_N,
  output logic [NARROW_W-1:0] rfa_M,
  output logic [NARROW_W-1:0] rfa_P,
  output logic [NARROW_W-1:0] rfa_ROW,
  output logic [NARROW_W-1:0] rfa_COL,
  output logic [NARROW_W-1:0] rfa_CURR,
  output logic [WIDE_W-1:0]   rfa_R,
  output logic [WIDE_W-1:0]   rfa_SUM,
  output logic [WIDE_W-1:0]   rfa_STA,
  output logic [WIDE_W-1:0]   rfa_STB,
  output logic [WIDE_W-1:0]   rfa_STC,
  output logic [WIDE_W-1:0]   rfa_A,
  output logic [WIDE_W-1:0]   rfa_B,
  output logic [WIDE_W-1:0]   rfa_R1,
  output logic                wr_ack,
  output logic [3:0]          wr_sel,
  output logic                wrap
);

  localparam int unsigned NUM_NAR  = 6;
  localparam int unsigned NUM_WIDE = 8;

  // Select codes, index 0 in the low nibble: N M P ROW COL CURR
  localparam logic [4*NUM_NAR-1:0]  NAR_CODES  = {4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1};
  // R SUM STA STB STC A B R1
  localparam logic [4*NUM_WIDE-1:0] WIDE_CODES = {4'd14, 4'd13, 4'd12, 4'd11,
                                                  4'd10, 4'd9,  4'd8,  4'd4};

  logic                w_wr_valid;
  logic [NUM_NAR-1:0]  w_wrap_nar;
  logic [NUM_WIDE-1:0] w_wrap_wide;
  logic                r_wr_ack;
  logic [3:0]          r_wr_sel;
  logic                r_wrap;

  assign w_wr_valid = RFA_en && (RFA_sel != 4'd0) && (RFA_sel != 4'd15);

  for (genvar g = 0; g < NUM_NAR; g++) begin : g_nar
    logic [NARROW_W-1:0] r_q;
    logic                w_wr;
    logic                w_clr;
    logic                w_inc;
    logic                w_full;

    assign w_wr   = RFA_en && (RFA_sel == NAR_CODES[4*g +: 4]);
    assign w_clr  = CLR_en && (CLR_sel == NAR_CODES[4*g +: 4]);
    assign w_inc  = INC_en && (INC_sel == NAR_CODES[4*g +: 4]);
    assign w_full = (r_q == {NARROW_W{1'b1}});
    // Increment that actually executes on an all-ones value
    assign w_wrap_nar[g] = w_inc && !w_wr && !w_clr && w_full;

    // Narrow register update: write beats clear beats increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_wr) begin
        r_q <= datain[NARROW_W-1:0];
      end else if (w_clr) begin
        r_q <= '0;
      end else if (w_inc) begin
`ifdef RFA_SAT_EN
        if (!w_full) r_q <= r_q + NARROW_W'(1);
`else
        r_q <= r_q + NARROW_W'(1);
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_WIDE; g++) begin : g_wide
    logic [WIDE_W-1:0] r_q;
    logic              w_wr;
    logic              w_clr;
    logic              w_inc;
    logic              w_full;

    assign w_wr   = RFA_en && (RFA_sel == WIDE_CODES[4*g +: 4]);
    assign w_clr  = CLR_en && (CLR_sel == WIDE_CODES[4*g +: 4]);
    assign w_inc  = INC_en && (INC_sel == WIDE_CODES[4*g +: 4]);
    assign w_full = (r_q == {WIDE_W{1'b1}});
    // Increment that actually executes on an all-ones value
    assign w_wrap_wide[g] = w_inc && !w_wr && !w_clr && w_full;

    // Wide register update: write beats clear beats increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_wr) begin
        r_q <= datain;
      end else if (w_clr) begin
        r_q <= '0;
      end else if (w_inc) begin
`ifdef RFA_SAT_EN
        if (!w_full) r_q <= r_q + WIDE_W'(1);
`else
        r_q <= r_q + WIDE_W'(1);
`endif
      end
    end
  end

  // Write acknowledge, last accepted select and wrap status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ack <= 1'b0;
      r_wr_sel <= 4'd0;
      r_wrap   <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_valid;
      if (w_wr_valid) r_wr_sel <= RFA_sel;
      r_wrap   <= (|w_wrap_nar) || (|w_wrap_wide);
    end
  end

  assign rfa_N    = g_nar[0].r_q;
  assign rfa_M    = g_nar[1].r_q;
  assign rfa_P    = g_nar[2].r_q;
  assign rfa_ROW  = g_nar[3].r_q;
  assign rfa_COL  = g_nar[4].r_q;
  assign rfa_CURR = g_nar[5].r_q;
  assign rfa_R    = g_wide[0].r_q;
  assign rfa_SUM  = g_wide[1].r_q;
  assign rfa_STA  = g_wide[2].r_q;
  assign rfa_STB  = g_wide[3].r_q;
  assign rfa_STC  = g_wide[4].r_q;
  assign rfa_A    = g_wide[5].r_q;
  assign rfa_B    = g_wide[6].r_q;
  assign rfa_R1   = g_wide[7].r_q;
  assign wr_ack   = r_wr_ack;
  assign wr_sel   = r_wr_sel;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_rfa_regbank.sv
// Bench for rfa_regbank: directed and random stimulus against a reference
// model; expected outputs are queued per cycle and checked by a monitor.
module tb_rfa_regbank;

  logic        clk;
  logic        rst;
  logic [3:0]  RFA_sel;
  logic        RFA_en;
  logic [15:0] datain;
  logic [3:0]  INC_sel;
  logic        INC_en;
  logic [3:0]  CLR_sel;
  logic        CLR_en;
  logic [7:0]  rfa_N, rfa_M, rfa_P, rfa_ROW, rfa_COL, rfa_CURR;
  logic [15:0] rfa_R, rfa_SUM, rfa_STA, rfa_STB, rfa_STC, rfa_A, rfa_B, rfa_R1;
  logic        wr_ack;
  logic [3:0]  wr_sel;
  logic        wrap;

  rfa_regbank dut (
    .clk(clk), .rst(rst),
    .RFA_sel(RFA_sel), .RFA_en(RFA_en), .datain(datain),
    .INC_sel(INC_sel), .INC_en(INC_en),
    .CLR_sel(CLR_sel), .CLR_en(CLR_en),
    .rfa_N(rfa_N), .rfa_M(rfa_M), .rfa_P(rfa_P),
    .rfa_ROW(rfa_ROW), .rfa_COL(rfa_COL), .rfa_CURR(rfa_CURR),
    .rfa_R(rfa_R), .rfa_SUM(rfa_SUM), .rfa_STA(rfa_STA), .rfa_STB(rfa_STB),
    .rfa_STC(rfa_STC), .rfa_A(rfa_A), .rfa_B(rfa_B), .rfa_R1(rfa_R1),
    .wr_ack(wr_ack), .wr_sel(wr_sel), .wrap(wrap)
  );

  typedef struct packed {
    logic [14:0][15:0] regs;
    logic              ack;
    logic [3:0]        sel;
    logic              wrap;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned m_reg[15];
  int unsigned m_sel;
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_narrow(int c);
    return (c == 1) || (c == 2) || (c == 3) || (c == 5) || (c == 6) || (c == 7);
  endfunction

  function automatic logic [14:0][15:0] dut_regs();
    logic [14:0][15:0] r;
    r     = '0;
    r[1]  = {8'h00, rfa_N};    r[2]  = {8'h00, rfa_M};
    r[3]  = {8'h00, rfa_P};    r[4]  = rfa_R;
    r[5]  = {8'h00, rfa_ROW};  r[6]  = {8'h00, rfa_COL};
    r[7]  = {8'h00, rfa_CURR}; r[8]  = rfa_SUM;
    r[9]  = rfa_STA;           r[10] = rfa_STB;
    r[11] = rfa_STC;           r[12] = rfa_A;
    r[13] = rfa_B;             r[14] = rfa_R1;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of operations to the model and queue the resulting outputs
  task automatic model_push(input bit en, input int sel, input int din,
                            input bit ien, input int isel, input bit cen, input int csel);
    exp_t        e;
    int unsigned mx;
    e = '0;
    for (int c = 1; c <= 14; c++) begin
      mx = is_narrow(c) ? 32'hFF : 32'hFFFF;
      if (en && sel == c) m_reg[c] = din & mx;
      else if (cen && csel == c) m_reg[c] = 0;
      else if (ien && isel == c) begin
        if (m_reg[c] == mx) begin
          e.wrap = 1'b1;
`ifdef RFA_SAT_EN
          m_reg[c] = mx;
`else
          m_reg[c] = 0;
`endif
        end else begin
          m_reg[c] = m_reg[c] + 1;
        end
      end
    end
    e.ack = en && sel >= 1 && sel <= 14;
    if (e.ack) m_sel = sel;
    e.sel = 4'(m_sel);
    for (int c = 1; c <= 14; c++) e.regs[c] = 16'(m_reg[c]);
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit en, input int sel, input int din,
                       input bit ien, input int isel, input bit cen, input int csel);
    RFA_en = en;  RFA_sel = 4'(sel); datain = 16'(din);
    INC_en = ien; INC_sel = 4'(isel);
    CLR_en = cen; CLR_sel = 4'(csel);
    model_push(en, sel, din, ien, isel, cen, csel);
  endtask

  task automatic step(input bit en, input int sel, input int din,
                      input bit ien, input int isel, input bit cen, input int csel);
    @(negedge clk);
    drive(en, sel, din, ien, isel, cen, csel);
  endtask

  // Monitor: after each rising edge compare DUT outputs to the oldest expectation
  initial begin
    exp_t              e;
    logic [14:0][15:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = dut_regs();
        for (int c = 1; c <= 14; c++) check($sformatf("reg%0d", c), a[c], e.regs[c]);
        check("wr_ack", 16'(wr_ack), 16'(e.ack));
        check("wr_sel", 16'(wr_sel), 16'(e.sel));
        check("wrap", 16'(wrap), 16'(e.wrap));
      end
    end
  end

  initial begin
    logic [14:0][15:0] a;
    rst = 1'b1;
    RFA_en = 0; RFA_sel = 0; datain = 0;
    INC_en = 0; INC_sel = 0; CLR_en = 0; CLR_sel = 0;
    for (int c = 0; c < 15; c++) m_reg[c] = 0;
    m_sel = 0;
    #3;
    a = dut_regs();
    for (int c = 1; c <= 14; c++) check($sformatf("rst_reg%0d", c), a[c], 16'h0);
    check("rst_wr_ack", 16'(wr_ack), 16'h0);
    check("rst_wr_sel", 16'(wr_sel), 16'h0);
    check("rst_wrap", 16'(wrap), 16'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Wide then narrow write of the same value
    step(1, 4, 'hABCD, 0, 0, 0, 0);
    step(1, 1, 'hABCD, 0, 0, 0, 0);
    // Invalid selects
    step(1, 0, 'h1234, 0, 0, 0, 0);
    step(1, 15, 'h1234, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // ROW increment across all-ones
    step(1, 5, 'h00FE, 0, 0, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Wide increment across all-ones
    step(1, 14, 'hFFFF, 0, 0, 0, 0);
    step(0, 0, 0, 1, 14, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Priority on one register, all three strobes then clear+increment
    step(1, 6, 'h0033, 0, 0, 0, 0);
    step(1, 7, 'h0055, 1, 7, 1, 7);
    step(0, 0, 0, 1, 6, 1, 6);
    // Write wins over an increment that would wrap, and no wrap is reported
    step(1, 3, 'h00FF, 0, 0, 0, 0);
    step(1, 3, 'h0012, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Random traffic, biased toward values that make increments wrap
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? 'hFFFF : int'($urandom_range(0, 'hFFFF));
      if ($urandom_range(0, 3) == 0) d = 'hFF;
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), d,
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)));
    end

    // Asynchronous reset in the middle of a cycle with a write pending
    step(1, 9, 'h5A5A, 0, 0, 0, 0);
    @(negedge clk);
    RFA_en = 1; RFA_sel = 4'd9; datain = 16'hFFFF;
    INC_en = 0; CLR_en = 0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_STA", rfa_STA, 16'h0);
    check("async_rst_wr_ack", 16'(wr_ack), 16'h0);
    for (int c = 0; c < 15; c++) m_reg[c] = 0;
    m_sel = 0;
    sb_q.push_back('0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rfa_regbank.md
Name: rfa_regbank

Overview:
- Receive-side counterpart of the write-to-accumulator (WTA) select path: it takes the 16-bit accumulator bus and writes it back into one of 14 processor registers, chosen by a 4-bit select.
- Also provides in-place increment and clear of any register, used for the loop counters ROW, COL and CURR.
- Register outputs feed the WTA select path, the address generator and the control unit.

Parameters:
- WIDE_W, 16, width of wide registers (R, SUM, STA, STB, STC, A, B, R1)
- NARROW_W, 8, width of narrow registers (N, M, P, ROW, COL, CURR)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- RFA_sel  in  4  write target: 1=N 2=M 3=P 4=R 5=ROW 6=COL 7=CURR 8=SUM 9=STA 10=STB 11=STC 12=A 13=B 14=R1; 0 and 15 select no register
- RFA_en  in  1  write strobe
- datain  in  16  accumulator bus
- INC_sel  in  4  increment target, same encoding as RFA_sel
- INC_en  in  1  increment strobe
- CLR_sel  in  4  clear target, same encoding as RFA_sel
- CLR_en  in  1  clear strobe
- rfa_N, rfa_M, rfa_P, rfa_ROW, rfa_COL, rfa_CURR  out  NARROW_W  register contents
- rfa_R, rfa_SUM, rfa_STA, rfa_STB, rfa_STC, rfa_A, rfa_B, rfa_R1  out  WIDE_W  register contents
- wr_ack  out  1  one-cycle pulse, the cycle after a valid write is accepted
- wr_sel  out  4  code of the last accepted write; holds its value between writes
- wrap  out  1  one-cycle pulse the cycle after an increment wraps a register

Behaviour:
- Reset (asynchronous, takes effect immediately on rst high): all 14 registers = 0; wr_ack = 0; wr_sel = 0; wrap = 0.
- Reset mid-operation overrides any in-flight strobe; nothing is written in that cycle.
- Write: on a rising clk edge with RFA_en=1 and RFA_sel in 1..14, the selected register loads datain.
  - Narrow registers take datain[NARROW_W-1:0]; upper bits are dropped.
  - New value is visible on the output the next cycle (1-cycle latency).
  - wr_ack=1 and wr_sel=RFA_sel in that same following cycle.
- Invalid select: RFA_sel 0 or 15 with RFA_en=1 changes no register and produces no wr_ack.
- Increment: with INC_en=1 and a valid INC_sel, the selected register becomes reg+1, modulo 2^width.
  - Wrap from all-ones to 0 produces a wrap pulse the next cycle.
- Clear: with CLR_en=1 and a valid CLR_sel, the selected register becomes 0.
- Same register, same cycle, priority: write > clear > increment.
  - A lower-priority operation on that register is discarded entirely and produces no wrap.
- Different registers, same cycle: all operations take effect independently.
- Write while an increment of the same register completes: the register takes datain; the increment is lost.
- Back-to-back writes every cycle are legal. wr_ack stays high for consecutive accepted writes; wr_sel tracks each one.
- Outputs are driven directly from registers; no combinational path from inputs to outputs.
- Control-unit sequencing: assert one strobe per register per instruction. Priority rules exist only for robustness.

Optional Feature:
- Macro: RFA_SAT_EN.
- Defined: increment saturates at all-ones (8'hFF narrow, 16'hFFFF wide); the register holds its value, and wrap pulses on the attempted increment at saturation.
- Undefined: increment wraps modulo 2^width as above; wrap pulses on the transition to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle: every register output 0, wr_ack 0, wr_sel 0, wrap 0.
- Write datain=16'hABCD to sel 4 (R), then to sel 1 (N) → next cycle rfa_R=16'hABCD, wr_ack=1, wr_sel=4; following cycle rfa_N=8'hCD, wr_sel=1.
- Write with sel 0 and sel 15 (datain 16'h1234) → no register changes, wr_ack stays 0.
- ROW=8'hFE, two consecutive increments on sel 5:
  - Default build → ROW goes FE→FF→00, wrap pulses once.
  - RFA_SAT_EN build → ROW stays FF, wrap pulses on the second increment.
- Same cycle, sel 7 (CURR): write 16'h0055, clear and increment → CURR=8'h55. Same cycle, sel 6 (COL) with only clear and increment → COL=0.
- rst asserted asynchronously mid-cycle while RFA_en=1, sel 9, datain 16'hFFFF → STA=0 immediately and after reset; no wr_ack.
